countdown_timer: RTL and testbench

Countdown counterpart to the stopwatch. It loads a four-digit BCD preset (SS.hh: tens of seconds, seconds, tenths, hundredths) and decrements it by one hundredth per 10 ms tick. It stops at 00.00 and latches a done flag. It sits between the board keys/switches and the existing seven-segment decoders, which take its four BCD outputs.

---
 rtl/countdown_timer.sv | 135 +++++++++++++
 tb/tb_countdown_timer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Four-digit BCD countdown timer (SS.hh) decrementing one hundredth per tick.
// Stops at 00.00 and holds a done flag until the next load or reset.
module countdown_timer #(
    parameter int TICK_DIV = 500000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        start_stop,
    output logic [3:0]  tens_bcd,
    output logic [3:0]  ones_bcd,
    output logic [3:0]  tenths_bcd,
    output logic [3:0]  hundredths_bcd,
    output logic        running,
    output logic        done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LP_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] LP_ONE  = PW'(1);

    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;

    logic [1:0]       r_state;
    logic [PW-1:0]    r_prescale;
    logic [3:0][3:0]  r_dig;
    logic             r_running;
    logic             r_done;

    logic [1:0]       w_nxt_state;
    logic [PW-1:0]    w_nxt_pre;
    logic [3:0][3:0]  w_nxt_dig;
    logic [3:0][3:0]  w_dec;
    logic [3:0][3:0]  w_clamp;
    logic [4:0]       w_bor;
    logic             w_tick;
    logic             w_zero;
    logic             w_dec_zero;

    function automatic logic [3:0] f_clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Digit 0 is hundredths; borrow ripples upward through zero digits.
    always_comb begin
        w_bor    = '0;
        w_bor[0] = 1'b1;
        w_dec    = r_dig;
        w_clamp  = '0;
        for (int i = 0; i < 4; i++) begin
            w_bor[i+1] = w_bor[i] && (r_dig[i] == 4'd0);
            if (w_bor[i]) begin
                if (r_dig[i] == 4'd0) begin
                    w_dec[i] = 4'd9;
                end else begin
                    w_dec[i] = r_dig[i] - 4'd1;
                end
            end
            w_clamp[i] = f_clamp(preset[4*i +: 4]);
        end
    end

    assign w_tick     = (r_prescale == LP_LAST);
    assign w_zero     = (r_dig == '0);
    assign w_dec_zero = (w_dec == '0);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pre   = r_prescale;
        w_nxt_dig   = r_dig;
        if (load) begin
            w_nxt_state = ST_STOPPED;
            w_nxt_pre   = '0;
            w_nxt_dig   = w_clamp;
        end else begin
            case (r_state)
                ST_STOPPED: begin
                    if (start_stop && !w_zero) begin
                        w_nxt_state = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    // A tick on the pause edge still decrements first.
                    if (w_tick) begin
                        w_nxt_pre = '0;
                        w_nxt_dig = w_dec;
                        if (w_dec_zero) begin
                            w_nxt_state = ST_EXPIRED;
                        end else if (start_stop) begin
                            w_nxt_state = ST_STOPPED;
                        end
                    end else begin
                        w_nxt_pre = r_prescale + LP_ONE;
                        if (start_stop) begin
                            w_nxt_state = ST_STOPPED;
                        end
                    end
                end
                ST_EXPIRED: begin
                    w_nxt_dig = '0;
                end
                default: begin
                    w_nxt_state = ST_STOPPED;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state    <= ST_STOPPED;
            r_prescale <= '0;
            r_dig      <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_prescale <= w_nxt_pre;
            r_dig      <= w_nxt_dig;
            r_running  <= (w_nxt_state == ST_RUNNING);
            r_done     <= (w_nxt_state == ST_EXPIRED);
        end
    end

    assign hundredths_bcd = r_dig[0];
    assign tenths_bcd     = r_dig[1];
    assign ones_bcd       = r_dig[2];
    assign tens_bcd       = r_dig[3];
    assign running        = r_running;
    assign done           = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer with TICK_DIV = 4.
// Expected {running, done, digits} words are queued with stimulus, popped after edges.
module tb_countdown_timer;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] preset;
    logic        start_stop;
    logic [3:0]  tens_bcd;
    logic [3:0]  ones_bcd;
    logic [3:0]  tenths_bcd;
    logic [3:0]  hundredths_bcd;
    logic        running;
    logic        done;

    typedef struct {
        string       name;
        logic [17:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    countdown_timer #(.TICK_DIV(4)) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .load          (load),
        .preset        (preset),
        .start_stop    (start_stop),
        .tens_bcd      (tens_bcd),
        .ones_bcd      (ones_bcd),
        .tenths_bcd    (tenths_bcd),
        .hundredths_bcd(hundredths_bcd),
        .running       (running),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] obs();
        return {running, done, tens_bcd, ones_bcd,
                tenths_bcd, hundredths_bcd};
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] b;
        b[15:12] = 4'((v / 1000) % 10);
        b[11:8]  = 4'((v / 100) % 10);
        b[7:4]   = 4'((v / 10) % 10);
        b[3:0]   = 4'(v % 10);
        return b;
    endfunction

    function automatic logic [17:0] mk(input logic r, input logic d,
                                       input logic [15:0] dg);
        return {r, d, dg};
    endfunction

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_load(input logic [15:0] p);
        preset = p;
        load   = 1'b1;
        cyc(1);
        load   = 1'b0;
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        exp_q.push_back('{"reset_state", mk(0, 0, 16'h0000)});
        cyc(2);
        reset = 1'b0;
        cyc(1);
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
        end
    endtask

    task automatic test_basic();
        pulse_load(16'h0012);
        exp_q.push_back('{"basic_load", mk(0, 0, 16'h0012)});
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
        end
        pulse_ss();
        exp_q.push_back('{"basic_start", mk(1, 0, 16'h0012)});
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
        end
        for (int k = 1; k <= 48; k++) begin
            int rem;
            rem = 12 - k / 4;
            exp_q.push_back('{$sformatf("basic_cyc%0d", k),
                              mk(rem > 0, rem == 0, to_bcd(rem))});
            cyc(1);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
            end
        end
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{"basic_ss_after_done", mk(0, 1, 16'h0000)});
            pulse_ss();
            cyc(2);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
            end
        end
    endtask

    task automatic test_borrow();
        logic [15:0] pre [2];
        logic [15:0] res [2];
        pre[0] = 16'h1000; res[0] = 16'h0999;
        pre[1] = 16'h0100; res[1] = 16'h0099;
        for (int i = 0; i < 2; i++) begin
            pulse_load(pre[i]);
            exp_q.push_back('{$sformatf("borrow_%0d", i), mk(1, 0, res[i])});
            pulse_ss();
            cyc(4);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
            end
        end
    endtask

    task automatic test_pause();
        pulse_load(16'h0050);
        pulse_ss();
        cyc(1);
        exp_q.push_back('{"pause_stop", mk(0, 0, 16'h0050)});
        pulse_ss();
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
        end
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back('{"pause_frozen", mk(0, 0, 16'h0050)});
            cyc(1);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
            end
        end
        exp_q.push_back('{"resume_edge", mk(1, 0, 16'h0050)});
        exp_q.push_back('{"resume_plus1", mk(1, 0, 16'h0050)});
        exp_q.push_back('{"resume_plus2", mk(1, 0, 16'h0049)});
        pulse_ss();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cyc(1);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
            end
        end
    endtask

    task automatic test_clamp_zero();
        exp_q.push_back('{"clamp", mk(0, 0, 16'h9993)});
        pulse_load(16'hF9A3);
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
        end
        exp_q.push_back('{"start_at_zero", mk(0, 0, 16'h0000)});
        pulse_load(16'h0000);
        pulse_ss();
        cyc(5);
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
        end
    endtask

    task automatic test_simultaneous();
        exp_q.push_back('{"load_and_ss", mk(0, 0, 16'h0005)});
        exp_q.push_back('{"load_and_ss_hold", mk(0, 0, 16'h0005)});
        preset     = 16'h0005;
        load       = 1'b1;
        start_stop = 1'b1;
        cyc(1);
        load       = 1'b0;
        start_stop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) cyc(6);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
            end
        end
        pulse_load(16'h0001);
        pulse_ss();
        cyc(3);
        exp_q.push_back('{"ss_on_final_tick", mk(0, 1, 16'h0000)});
        pulse_ss();
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_load(16'h0037);
        pulse_ss();
        cyc(2);
        exp_q.push_back('{"pre_reset", mk(1, 0, 16'h0037)});
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
        end
        exp_q.push_back('{"async_reset", mk(0, 0, 16'h0000)});
        #2;
        reset = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
        end
        cyc(1);
        reset = 1'b0;
        exp_q.push_back('{"ss_after_reset", mk(0, 0, 16'h0000)});
        pulse_ss();
        cyc(5);
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
        end
    endtask

    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        preset     = 16'h0000;
        start_stop = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_borrow();
        test_pause();
        test_clamp_zero();
        test_simultaneous();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
